// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: shares one single-ported, variable-latency memory between
// the IF and MEM pipeline stages. Data requests win over fetches, but after
// MAX_D_STREAK back-to-back D grants with IF waiting, IF is forced a grant.
// Optional feature macro: ARB_PERF_CNT_EN (wait-cycle performance counters).
module cpu_mem_arbiter #(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 64,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  input  logic            if_kill,
  output logic            if_ready,
  output logic [DW-1:0]   if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic            d_ready,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_ack,
  input  logic [DW-1:0]   mem_rdata,
  output logic            stall,
  output logic [31:0]     perf_if_wait,
  output logic [31:0]     perf_d_wait
);

  localparam int unsigned BEW = DW / 8;
  localparam int unsigned SW  = 4;
  localparam int unsigned PW  = 32;

  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_e;

  state_e          state_q, state_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [BEW-1:0]  mem_be_q, mem_be_d;
  logic            if_ready_q, if_ready_d;
  logic            d_ready_q, d_ready_d;
  logic [DW-1:0]   if_rdata_q, if_rdata_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic            kill_pending_q, kill_pending_d;
  logic [SW-1:0]   streak_q, streak_d;
  logic            streak_max;

  assign streak_max = (streak_q == SW'(MAX_D_STREAK));

  // Arbitration, memory handshake and response sequencing.
  always_comb begin
    state_d        = state_q;
    mem_req_d      = mem_req_q;
    mem_we_d       = mem_we_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    mem_be_d       = mem_be_q;
    if_ready_d     = 1'b0;
    d_ready_d      = 1'b0;
    if_rdata_d     = if_rdata_q;
    d_rdata_d      = d_rdata_q;
    kill_pending_d = kill_pending_q;
    streak_d       = streak_q;
    case (state_q)
      IDLE: begin
        if (d_req && !(if_req && streak_max)) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_be_d    = d_be;
          if (if_req) begin
            streak_d = streak_max ? streak_q : streak_q + SW'(1);
          end else begin
            streak_d = '0;
          end
        end else if (if_req) begin
          state_d        = BUSY_I;
          mem_req_d      = 1'b1;
          mem_we_d       = 1'b0;
          mem_addr_d     = if_addr;
          mem_wdata_d    = '0;
          mem_be_d       = '0;
          streak_d       = '0;
          kill_pending_d = 1'b0;
        end
      end
      BUSY_I: begin
        // A kill never aborts the memory access; it only hides the result.
        if (mem_ack) begin
          state_d        = RESP_I;
          mem_req_d      = 1'b0;
          kill_pending_d = kill_pending_q | if_kill;
          if (!(kill_pending_q || if_kill)) begin
            if_ready_d = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else if (if_kill) begin
          kill_pending_d = 1'b1;
        end
      end
      BUSY_D: begin
        if (mem_ack) begin
          state_d   = RESP_D;
          mem_req_d = 1'b0;
          d_ready_d = 1'b1;
          if (!mem_we_q) begin
            d_rdata_d = mem_rdata;
          end
        end
      end
      RESP_I: begin
        state_d        = IDLE;
        kill_pending_d = 1'b0;
      end
      RESP_D: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      mem_be_q       <= '0;
      if_ready_q     <= 1'b0;
      d_ready_q      <= 1'b0;
      if_rdata_q     <= '0;
      d_rdata_q      <= '0;
      kill_pending_q <= 1'b0;
      streak_q       <= '0;
    end else begin
      state_q        <= state_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      mem_be_q       <= mem_be_d;
      if_ready_q     <= if_ready_d;
      d_ready_q      <= d_ready_d;
      if_rdata_q     <= if_rdata_d;
      d_rdata_q      <= d_rdata_d;
      kill_pending_q <= kill_pending_d;
      streak_q       <= streak_d;
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [PW-1:0] perf_if_wait_q, perf_if_wait_d;
  logic [PW-1:0] perf_d_wait_q, perf_d_wait_d;

  // Saturating counts of cycles each requester spends waiting.
  always_comb begin
    perf_if_wait_d = perf_if_wait_q;
    perf_d_wait_d  = perf_d_wait_q;
    if (if_req && !if_ready_q && (perf_if_wait_q != '1)) begin
      perf_if_wait_d = perf_if_wait_q + PW'(1);
    end
    if (d_req && !d_ready_q && (perf_d_wait_q != '1)) begin
      perf_d_wait_d = perf_d_wait_q + PW'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_if_wait_q <= '0;
      perf_d_wait_q  <= '0;
    end else begin
      perf_if_wait_q <= perf_if_wait_d;
      perf_d_wait_q  <= perf_d_wait_d;
    end
  end

  assign perf_if_wait = perf_if_wait_q;
  assign perf_d_wait  = perf_d_wait_q;
`else
  assign perf_if_wait = PW'(0);
  assign perf_d_wait  = PW'(0);
`endif

  assign if_ready  = if_ready_q;
  assign if_rdata  = if_rdata_q;
  assign d_ready   = d_ready_q;
  assign d_rdata   = d_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign stall     = (if_req & ~if_ready_q) | (d_req & ~d_ready_q);

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed self-checking bench for cpu_mem_arbiter (default parameters).
// Honours ARB_PERF_CNT_EN for the expected performance-counter values.
module tb_cpu_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;

`ifdef ARB_PERF_CNT_EN
  localparam logic [63:0] EXP_IF_WAIT = 64'd5;
  localparam logic [63:0] EXP_D_WAIT  = 64'd2;
`else
  localparam logic [63:0] EXP_IF_WAIT = 64'd0;
  localparam logic [63:0] EXP_D_WAIT  = 64'd0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            if_req;
  logic [AW-1:0]   if_addr;
  logic            if_kill;
  logic            if_ready;
  logic [DW-1:0]   if_rdata;
  logic            d_req;
  logic            d_we;
  logic [AW-1:0]   d_addr;
  logic [DW-1:0]   d_wdata;
  logic [DW/8-1:0] d_be;
  logic            d_ready;
  logic [DW-1:0]   d_rdata;
  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_be;
  logic            mem_ack;
  logic [DW-1:0]   mem_rdata;
  logic            stall;
  logic [31:0]     perf_if_wait;
  logic [31:0]     perf_d_wait;

  int n_cmp = 0;
  int n_err = 0;

  cpu_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_ready(if_ready), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall(stall), .perf_if_wait(perf_if_wait), .perf_d_wait(perf_d_wait)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [AW-1:0] exp_addr [10];
    int n;

    reset = 1'b0; if_req = 1'b0; if_addr = '0; if_kill = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    cyc();
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_if_ready", 64'(if_ready), 64'd0);
    chk("rst_d_ready", 64'(d_ready), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);

    // Single IF read, ack one cycle after mem_req.
    if_req = 1'b1; if_addr = 32'h40;
    #1 chk("t1_stall_c0", 64'(stall), 64'd1);
    chk("t1_mem_req_c0", 64'(mem_req), 64'd0);
    cyc();
    chk("t1_mem_req_c1", 64'(mem_req), 64'd1);
    chk("t1_mem_addr_c1", 64'(mem_addr), 64'h40);
    chk("t1_mem_we_c1", 64'(mem_we), 64'd0);
    chk("t1_stall_c1", 64'(stall), 64'd1);
    mem_ack = 1'b1; mem_rdata = 64'h1111_2222_3333_4444;
    cyc();
    chk("t1_if_ready_c2", 64'(if_ready), 64'd1);
    chk("t1_if_rdata_c2", if_rdata, 64'h1111_2222_3333_4444);
    chk("t1_mem_req_c2", 64'(mem_req), 64'd0);
    chk("t1_stall_c2", 64'(stall), 64'd0);
    mem_ack = 1'b0; if_req = 1'b0;
    cyc();
    chk("t1_if_ready_c3", 64'(if_ready), 64'd0);
    chk("t1_if_rdata_hold", if_rdata, 64'h1111_2222_3333_4444);

    // Simultaneous IF and D write, ack latency 3: D first, then IF.
    if_req = 1'b1; if_addr = 32'h80;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_be = 8'h0F;
    d_wdata = 64'hAAAA_BBBB_CCCC_DDDD;
    cyc();
    chk("t2_mem_req", 64'(mem_req), 64'd1);
    chk("t2_mem_we", 64'(mem_we), 64'd1);
    chk("t2_mem_addr", 64'(mem_addr), 64'h100);
    chk("t2_mem_be", 64'(mem_be), 64'h0F);
    chk("t2_mem_wdata", mem_wdata, 64'hAAAA_BBBB_CCCC_DDDD);
    cyc();
    chk("t2_mem_req_hold", 64'(mem_req), 64'd1);
    cyc();
    mem_ack = 1'b1; mem_rdata = 64'h5555_5555_5555_5555;
    cyc();
    chk("t2_d_ready", 64'(d_ready), 64'd1);
    chk("t2_if_ready_no", 64'(if_ready), 64'd0);
    chk("t2_d_rdata_write", d_rdata, 64'd0);
    chk("t2_mem_req_drop", 64'(mem_req), 64'd0);
    chk("t2_stall_if_wait", 64'(stall), 64'd1);
    mem_ack = 1'b0; d_req = 1'b0; d_we = 1'b0;
    cyc();
    chk("t2_d_ready_pulse", 64'(d_ready), 64'd0);
    chk("t2_idle_no_req", 64'(mem_req), 64'd0);
    cyc();
    chk("t2_if_grant", 64'(mem_req), 64'd1);
    chk("t2_if_addr", 64'(mem_addr), 64'h80);
    chk("t2_if_we", 64'(mem_we), 64'd0);
    mem_ack = 1'b1; mem_rdata = 64'h6666_7777_8888_9999;
    cyc();
    chk("t2_if_ready", 64'(if_ready), 64'd1);
    chk("t2_if_rdata", if_rdata, 64'h6666_7777_8888_9999);
    mem_ack = 1'b0; if_req = 1'b0;
    cyc();

    // Starvation bound: grant order D,D,D,D,I,D,D,D,D,I.
    for (int i = 0; i < 10; i++) exp_addr[i] = 32'h200;
    exp_addr[4] = 32'h300;
    exp_addr[9] = 32'h300;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    if_req = 1'b1; if_addr = 32'h300;
    for (int i = 0; i < 10; i++) begin
      n = 0;
      while (mem_req !== 1'b1 && n < 20) begin
        cyc();
        n++;
      end
      chk("t3_grant_wait", 64'(mem_req), 64'd1);
      chk($sformatf("t3_grant_%0d", i), 64'(mem_addr), 64'(exp_addr[i]));
      mem_ack = 1'b1; mem_rdata = 64'hCAFE_0000_0000_0000 | 64'(i);
      cyc();
      mem_ack = 1'b0;
    end
    d_req = 1'b0; if_req = 1'b0;
    chk("t3_d_rdata", d_rdata, 64'hCAFE_0000_0000_0008);
    chk("t3_if_rdata", if_rdata, 64'hCAFE_0000_0000_0009);
    cyc();

    // Kill during BUSY_I: access completes silently.
    if_req = 1'b1; if_addr = 32'h500;
    cyc();
    chk("t4_mem_req", 64'(mem_req), 64'd1);
    chk("t4_mem_addr", 64'(mem_addr), 64'h500);
    if_kill = 1'b1;
    cyc();
    if_kill = 1'b0; if_req = 1'b0;
    chk("t4_mem_req_hold", 64'(mem_req), 64'd1);
    mem_ack = 1'b1; mem_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
    cyc();
    chk("t4_if_ready_supp", 64'(if_ready), 64'd0);
    chk("t4_if_rdata_keep", if_rdata, 64'hCAFE_0000_0000_0009);
    chk("t4_mem_req_drop", 64'(mem_req), 64'd0);
    mem_ack = 1'b0;
    cyc();
    chk("t4_if_ready_idle", 64'(if_ready), 64'd0);

    // Kill in the same cycle as the ack.
    if_req = 1'b1; if_addr = 32'h580;
    cyc();
    chk("t4b_mem_req", 64'(mem_req), 64'd1);
    if_kill = 1'b1; mem_ack = 1'b1; mem_rdata = 64'hBEEF_BEEF_BEEF_BEEF;
    cyc();
    chk("t4b_if_ready_supp", 64'(if_ready), 64'd0);
    chk("t4b_if_rdata_keep", if_rdata, 64'hCAFE_0000_0000_0009);
    if_kill = 1'b0; mem_ack = 1'b0; if_req = 1'b0;
    cyc();

    // Normal fetch after kills must respond again.
    if_req = 1'b1; if_addr = 32'h5C0;
    cyc();
    chk("t4c_mem_addr", 64'(mem_addr), 64'h5C0);
    mem_ack = 1'b1; mem_rdata = 64'h0E0E_0E0E_0E0E_0E0E;
    cyc();
    chk("t4c_if_ready", 64'(if_ready), 64'd1);
    chk("t4c_if_rdata", if_rdata, 64'h0E0E_0E0E_0E0E_0E0E);
    mem_ack = 1'b0; if_req = 1'b0;
    cyc();

    // Async reset in the middle of BUSY_D.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
    cyc();
    chk("t5_mem_req", 64'(mem_req), 64'd1);
    chk("t5_mem_addr", 64'(mem_addr), 64'h600);
    #1 reset = 1'b0; d_req = 1'b0;
    #1 chk("t5_async_mem_req", 64'(mem_req), 64'd0);
    chk("t5_async_mem_addr", 64'(mem_addr), 64'd0);
    chk("t5_async_if_rdata", if_rdata, 64'd0);
    chk("t5_async_d_rdata", d_rdata, 64'd0);
    cyc();
    reset = 1'b1;
    mem_ack = 1'b1; mem_rdata = 64'h1234_5678_9ABC_DEF0;
    cyc();
    chk("t5_late_ack_d_ready", 64'(d_ready), 64'd0);
    chk("t5_late_ack_mem_req", 64'(mem_req), 64'd0);
    cyc();
    chk("t5_late_ack_d_ready2", 64'(d_ready), 64'd0);
    mem_ack = 1'b0;
    if_req = 1'b1; if_addr = 32'h700;
    cyc();
    chk("t5_if_mem_req", 64'(mem_req), 64'd1);
    chk("t5_if_mem_addr", 64'(mem_addr), 64'h700);
    mem_ack = 1'b1; mem_rdata = 64'hF0F0_F0F0_F0F0_F0F0;
    cyc();
    chk("t5_if_ready", 64'(if_ready), 64'd1);
    chk("t5_if_rdata", if_rdata, 64'hF0F0_F0F0_F0F0_F0F0);
    mem_ack = 1'b0; if_req = 1'b0;
    cyc();

    // Performance counters: IF waits 5 cycles, D waits 2.
    #1 reset = 1'b0;
    #1 reset = 1'b1;
    cyc();
    chk("t6_perf_if_clr", 64'(perf_if_wait), 64'd0);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h800;
    if_req = 1'b1; if_addr = 32'h900;
    cyc();
    chk("t6_d_addr", 64'(mem_addr), 64'h800);
    mem_ack = 1'b1; mem_rdata = 64'h0101_0101_0101_0101;
    cyc();
    chk("t6_d_ready", 64'(d_ready), 64'd1);
    mem_ack = 1'b0; d_req = 1'b0;
    cyc();
    cyc();
    chk("t6_if_addr", 64'(mem_addr), 64'h900);
    mem_ack = 1'b1; mem_rdata = 64'h0202_0202_0202_0202;
    cyc();
    chk("t6_if_ready", 64'(if_ready), 64'd1);
    chk("t6_perf_if_wait", 64'(perf_if_wait), EXP_IF_WAIT);
    chk("t6_perf_d_wait", 64'(perf_d_wait), EXP_D_WAIT);
    mem_ack = 1'b0; if_req = 1'b0;
    cyc();
    chk("t6_perf_if_hold", 64'(perf_if_wait), EXP_IF_WAIT);
    chk("t6_perf_d_hold", 64'(perf_d_wait), EXP_D_WAIT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_mem_arbiter.md
Name: cpu_mem_arbiter

Overview:
- Shares one single-ported, variable-latency unified memory between the pipelined CPU's instruction-fetch (IF) stage and its data-memory (MEM) stage.
- Sits between the pipeline and the memory model.
- Serialises requests with data-over-instruction priority and bounded starvation.
- Produces a pipeline-wide stall signal and per-requester ready pulses with returned read data.

Parameters:
- AW, 32, address width in bits.
- DW, 64, data width in bits; must be a multiple of 8.
- MAX_D_STREAK, 4, maximum consecutive D grants while IF is waiting before IF is forced a grant; range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- if_req  in  1  IF read request; held with if_addr stable until if_ready.
- if_addr  in  AW  fetch address.
- if_kill  in  1  flush of the outstanding fetch (branch taken).
- if_ready  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  DW  fetched data.
- d_req  in  1  data request; held with d_we/d_addr/d_wdata/d_be stable until d_ready.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  AW  data address.
- d_wdata  in  DW  write data.
- d_be  in  DW/8  byte enables; ignored on reads.
- d_ready  out  1  one-cycle pulse: access complete; d_rdata valid on reads.
- d_rdata  out  DW  read data.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we, mem_addr, mem_wdata, mem_be  out  1/AW/DW/DW/8  registered copies of the granted request.
- mem_ack  in  1  memory completion; sampled only while mem_req=1.
- mem_rdata  in  DW  valid in the mem_ack cycle.
- stall  out  1  combinational: (if_req & ~if_ready) | (d_req & ~d_ready).
- perf_if_wait, perf_d_wait  out  32 each  performance counters (see Optional Feature).

Behaviour:
- States: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
- IDLE, arbitration:
  - If d_req=1 and not (if_req=1 and streak==MAX_D_STREAK): go to BUSY_D; streak increments when if_req=1, else clears.
  - Else if if_req=1: go to BUSY_I; streak clears.
  - Else stay in IDLE.
- On entering BUSY_x: mem_req and the mem_* fields are registered from the granted requester. mem_req=1 throughout BUSY_x.
- BUSY_x + mem_ack=1: capture mem_rdata into x_rdata, drop mem_req, go to RESP_x. Without mem_ack, stay in BUSY_x.
- RESP_x: x_ready=1 for exactly one cycle, then IDLE. Re-arbitration happens in IDLE, so the minimum access is 3 cycles: grant, ack, ready.
- if_kill, while BUSY_I or in the same cycle as the BUSY_I ack:
  - The memory transaction still completes.
  - A kill_pending flag suppresses if_ready in RESP_I; if_rdata is not updated.
- if_kill at any other time is ignored. The IF requester may drop or change if_req the cycle after if_kill.
- Reads: d_rdata and if_rdata hold their last value until the next update of the same requester.
- Writes: d_rdata is not updated.
- mem_ack in IDLE or RESP_x: ignored.
- streak saturates at MAX_D_STREAK. streak == MAX_D_STREAK with if_req=1 forces an IF grant even if d_req=1.
- Reset (async, any state, including mid-transaction):
  - State returns to IDLE.
  - mem_req, if_ready, d_ready, kill_pending and streak are 0.
  - mem_* fields, if_rdata, d_rdata and perf counters are 0.
  - Any in-flight memory transaction is abandoned; a late mem_ack after reset is ignored.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Defined: perf_if_wait increments every cycle with if_req=1 & if_ready=0; perf_d_wait likewise for D. Both saturate at 2^32-1 and clear on reset.
- Undefined: counter logic is omitted and both ports are driven constant 0; the port list is unchanged.

Test Plan:
- Single IF read, memory acks 1 cycle after mem_req: if_req@c0 with addr 0x40 -> mem_req@c1 with mem_addr=0x40; ack@c1 -> if_ready=1@c2 with if_rdata=mem_rdata; stall=1 for c0-c1, 0@c2.
- Simultaneous if_req and d_req (write, addr 0x100, be=0x0F), ack latency 3: D is granted first and d_ready pulses; IF is granted next IDLE cycle; mem_we=1 only during the D transaction.
- Starvation, MAX_D_STREAK=4, d_req and if_req held continuously: grant order is D,D,D,D,I,D,D,D,D,I.
- if_kill asserted during BUSY_I: mem_ack completes the transaction, no if_ready pulse, if_rdata unchanged, state returns to IDLE.
- reset driven low mid-BUSY_D with mem_req=1: mem_req=0 immediately without waiting for clk; a later mem_ack produces no d_ready; after release, a new if_req is served normally.
- With ARB_PERF_CNT_EN: IF waits 5 cycles behind a D access -> perf_if_wait=5 after if_ready. Without the macro: both counters read 0.
